// File: rtl/if_weight_reader.sv
// Read-side master for the if_network weight memory: walks every weight
// address of one layer in neuron-major order and streams the words out.
module if_weight_reader #(
    parameter int WEIGHT_SIZE       = 32,
    parameter int LAYER_ADDR_WIDTH  = 32,
    parameter int NEURON_ADDR_WIDTH = 28,
    parameter int WEIGHT_ADDR_WIDTH = 10
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [LAYER_ADDR_WIDTH-NEURON_ADDR_WIDTH-1:0]   cfg_layer,
    input  logic [NEURON_ADDR_WIDTH-WEIGHT_ADDR_WIDTH-1:0]  cfg_num_neurons,
    input  logic [WEIGHT_ADDR_WIDTH:0]                      cfg_num_inputs,
    input  logic                                            abort,
    output logic [LAYER_ADDR_WIDTH-1:0]                     mem_addr,
    output logic [WEIGHT_SIZE-1:0]                          mem_din,
    output logic                                            mem_wen,
    input  logic [WEIGHT_SIZE-1:0]                          mem_dout,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [WEIGHT_SIZE-1:0]                          out_data,
    output logic [NEURON_ADDR_WIDTH-WEIGHT_ADDR_WIDTH-1:0]  out_neuron,
    output logic [WEIGHT_ADDR_WIDTH-1:0]                    out_index,
    output logic                                            out_last,
    output logic                                            busy,
    output logic                                            done
);
    localparam int LW = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
    localparam int NW = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
    localparam int WW = WEIGHT_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, OUT} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] layer_q;
    logic [NW-1:0] nn_q;
    logic [NW-1:0] j_q;
    logic [NW-1:0] j_nxt;
    logic [WW:0]   ni_q;
    logic [WW:0]   i_q;
    logic [WW:0]   i_inc;
    logic [WW:0]   i_nxt;
    logic          cfg_ok;
    logic          hs;
    logic          wrap;
    logic          is_last;
    logic          kill;

    assign mem_din = '0;
    assign mem_wen = 1'b0;
    assign busy    = (state_q != IDLE);

    assign cfg_ok  = (cfg_num_neurons != '0) && (cfg_num_inputs != '0);
    assign hs      = out_valid && out_ready;
    assign kill    = abort && (state_q != IDLE);
    assign i_inc   = i_q + 1'b1;
    assign wrap    = (i_inc == ni_q);
    assign i_nxt   = wrap ? '0 : i_inc;
    assign j_nxt   = wrap ? j_q + 1'b1 : j_q;
    assign is_last = (j_q == nn_q - 1'b1) && (i_q == ni_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && cfg_ok) state_d = ADDR;
            ADDR:    state_d = WAIT;
            WAIT:    state_d = OUT;
            OUT:     if (hs) state_d = out_last ? IDLE : ADDR;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // mem_addr is loaded on entry to ADDR so the synchronous read lands in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_q    <= '0;
            nn_q       <= '0;
            ni_q       <= '0;
            j_q        <= '0;
            i_q        <= '0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_neuron <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                layer_q  <= cfg_layer;
                                nn_q     <= cfg_num_neurons;
                                ni_q     <= cfg_num_inputs;
                                j_q      <= '0;
                                i_q      <= '0;
                                mem_addr <= {cfg_layer, {NW{1'b0}}, {WW{1'b0}}};
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        out_data   <= mem_dout;
                        out_neuron <= j_q;
                        out_index  <= i_q[WW-1:0];
                        out_last   <= is_last;
                        out_valid  <= 1'b1;
                    end
                    OUT: begin
                        if (hs) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_last) begin
                                done <= 1'b1;
                            end else begin
                                i_q      <= i_nxt;
                                j_q      <= j_nxt;
                                mem_addr <= {layer_q, j_nxt, i_nxt[WW-1:0]};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_if_weight_reader.sv
// Directed bench for if_weight_reader with a synchronous-read weight memory.
module tb_if_weight_reader;
    localparam int WS  = 32;
    localparam int LAW = 32;
    localparam int NAW = 28;
    localparam int WAW = 10;
    localparam int LW  = LAW - NAW;
    localparam int NW  = NAW - WAW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           out_ready = 1'b1;
    logic [LW-1:0]  cfg_layer = '0;
    logic [NW-1:0]  cfg_num_neurons = '0;
    logic [WAW:0]   cfg_num_inputs = '0;
    logic [LAW-1:0] mem_addr;
    logic [WS-1:0]  mem_din;
    logic [WS-1:0]  mem_dout = '0;
    logic           mem_wen;
    logic           out_valid;
    logic           out_last;
    logic           busy;
    logic           done;
    logic [WS-1:0]  out_data;
    logic [NW-1:0]  out_neuron;
    logic [WAW-1:0] out_index;

    int checks = 0;
    int errors = 0;
    int wen_bad = 0;
    int stall_seen = 0;
    int words;
    int nd;
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];
    logic [31:0] addr_tbl[6];

    if_weight_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_layer(cfg_layer), .cfg_num_neurons(cfg_num_neurons),
        .cfg_num_inputs(cfg_num_inputs), .abort(abort),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_neuron(out_neuron), .out_index(out_index),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Layer 0: even i -> -(i+1), odd i -> i+1; other layers: ~address
    function automatic logic [31:0] wfun(input logic [31:0] a);
        logic [31:0] i;
        i = {22'd0, a[9:0]};
        if (a[31:28] == 4'd0) return i[0] ? i + 1 : -(i + 1);
        return ~a;
    endfunction

    always @(posedge clk) mem_dout <= wfun(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input int layer, input int nn, input int ni,
                      input bit with_abort);
        cfg_layer       = LW'(layer);
        cfg_num_neurons = NW'(nn);
        cfg_num_inputs  = (WAW+1)'(ni);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Start a dump and check the two-cycle latency to the first word
    task automatic go_first(input int layer, input int nn, input int ni,
                            input bit with_abort);
        go(layer, nn, ni, with_abort);
        check("busy_addr", busy, 1);
        check("valid_addr", out_valid, 0);
        @(negedge clk);
        check("valid_wait", out_valid, 0);
        @(negedge clk);
        check("valid_lat2", out_valid, 1);
    endtask

    task automatic collect(input int layer, input int nn, input int ni,
                           input int stall_at, input int abort_at,
                           input int bstart_at,
                           output int nw, output int ndone);
        int stall_left;
        int cyc;
        int post;
        int j;
        int i;
        bit fin;
        logic [31:0] ea;
        stall_left = 5;
        cyc = 0;
        post = 0;
        fin = 1'b0;
        nw = 0;
        ndone = 0;
        out_ready = 1'b1;
        while (!fin && cyc < 3000) begin
            start = 1'b0;
            if (mem_wen !== 1'b0) wen_bad++;
            if (done) begin
                ndone++;
                check("busy_at_done", busy, 0);
            end
            if (out_valid) begin
                j  = nw / ni;
                i  = nw % ni;
                ea = (layer << 28) | (j << 10) | i;
                check("neuron", out_neuron, j);
                check("index", out_index, i);
                check("data", out_data, wfun(ea));
                check("addr", mem_addr, ea);
                check("last", out_last, nw == nn * ni - 1);
                if (nw == abort_at) begin
                    abort = 1'b1;
                    fin = 1'b1;
                end else if (nw == stall_at && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    out_ready = 1'b1;
                    addr_log.push_back(mem_addr);
                    data_log.push_back(out_data);
                    nw++;
                    if (nw == bstart_at) begin
                        start = 1'b1;
                        cfg_layer = 2;
                        cfg_num_neurons = 1;
                        cfg_num_inputs = 1;
                    end
                end
            end
            if (ndone > 0) post++;
            if (post >= 3) fin = 1'b1;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        out_ready = 1'b1;
        check("no_timeout", cyc < 3000, 1);
    endtask

    initial begin
        addr_tbl = '{32'h2000_0000, 32'h2000_0001, 32'h2000_0002,
                     32'h2000_0400, 32'h2000_0401, 32'h2000_0402};
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_din", mem_din, 0);
        check("rst_last", out_last, 0);
        rst = 1'b1;
        @(negedge clk);

        // readback of layer 0, 4 x 8
        addr_log.delete();
        data_log.delete();
        go_first(0, 4, 8, 1'b0);
        collect(0, 4, 8, -1, -1, -1, words, nd);
        check("rb_words", words, 32);
        check("rb_done", nd, 1);
        check("rb_w0", data_log[0], 32'hFFFF_FFFF);
        check("rb_w3", data_log[3], 32'h0000_0004);
        check("rb_w31", data_log[31], 32'h0000_0008);
        check("rb_wen", wen_bad, 0);

        // address sequence for layer 2, 2 x 3
        addr_log.delete();
        go_first(2, 2, 3, 1'b0);
        collect(2, 2, 3, -1, -1, -1, words, nd);
        check("ad_words", words, 6);
        check("ad_done", nd, 1);
        for (int k = 0; k < 6; k++) check("ad_seq", addr_log[k], addr_tbl[k]);

        // backpressure on word 2
        go_first(0, 4, 8, 1'b0);
        collect(0, 4, 8, 2, -1, -1, words, nd);
        check("bp_words", words, 32);
        check("bp_done", nd, 1);
        check("bp_stalls", stall_seen, 5);

        // zero counts
        go(0, 0, 8, 1'b0);
        check("z0_done", done, 1);
        check("z0_busy", busy, 0);
        check("z0_valid", out_valid, 0);
        @(negedge clk);
        check("z0_done_end", done, 0);
        go(0, 4, 0, 1'b0);
        check("z1_done", done, 1);
        check("z1_busy", busy, 0);
        @(negedge clk);
        check("z1_valid", out_valid, 0);

        // abort in idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ia_busy", busy, 0);
        check("ia_done", done, 0);

        // abort while OUT holds word 10
        go_first(0, 4, 8, 1'b0);
        collect(0, 4, 8, -1, 10, -1, words, nd);
        check("ab_words", words, 10);
        @(negedge clk);
        abort = 1'b0;
        check("ab_valid", out_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 1);
        @(negedge clk);
        check("ab_done_end", done, 0);

        // start with abort in idle: start wins, replay from (0,0)
        data_log.delete();
        go_first(0, 4, 8, 1'b1);
        collect(0, 4, 8, -1, -1, -1, words, nd);
        check("rp_words", words, 32);
        check("rp_done", nd, 1);
        check("rp_w0", data_log[0], 32'hFFFF_FFFF);

        // reset during WAIT
        go(1, 1, 2, 1'b0);
        check("rs_addr_pre", mem_addr, 32'h1000_0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs_valid", out_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_addr", mem_addr, 0);
        check("rs_data", out_data, 0);
        check("rs_index", out_index, 0);
        check("rs_neuron", out_neuron, 0);
        check("rs_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rs_post_done", done, 0);
            check("rs_post_busy", busy, 0);
        end

        // start while busy is ignored
        go_first(0, 4, 8, 1'b0);
        collect(0, 4, 8, -1, -1, 5, words, nd);
        check("sb_words", words, 32);
        check("sb_done", nd, 1);
        check("sb_wen", wen_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
